// File: rtl/mm_pkg.sv
// Shared definitions for the 2x2 matrix multiplier: element width, element
// count, packing order of the operand matrices and loader FSM states.
package mm_pkg;

  localparam int MM_ELEM_W = 8;
  localparam int MM_N_ELEM = 8;

  // Element slot order; A occupies slots 0..3, B occupies 4..7.
  localparam logic [2:0] IDX_A00 = 3'd0;
  localparam logic [2:0] IDX_A01 = 3'd1;
  localparam logic [2:0] IDX_A10 = 3'd2;
  localparam logic [2:0] IDX_A11 = 3'd3;
  localparam logic [2:0] IDX_B00 = 3'd4;
  localparam logic [2:0] IDX_B01 = 3'd5;
  localparam logic [2:0] IDX_B10 = 3'd6;
  localparam logic [2:0] IDX_B11 = 3'd7;

  typedef enum logic {
    ST_LOAD = 1'b0,
    ST_HOLD = 1'b1
  } mm_state_e;

endpackage

// File: rtl/mm_sync_edge.sv
// Synchronizes an asynchronous level and emits a single-clock pulse on each
// rising edge of the synchronized signal.
module mm_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic async_in,
  output logic rise_pulse
);

  logic [SYNC_STAGES-1:0] sync_p0;
  logic                   dly_p1;

  // Synchronizer chain followed by one delay flop for edge detection
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_p0 <= '0;
      dly_p1  <= 1'b0;
    end else begin
      sync_p0 <= {sync_p0[SYNC_STAGES-2:0], async_in};
      dly_p1  <= sync_p0[SYNC_STAGES-1];
    end
  end

  // stage boundary: synchronized level vs. its one-cycle-delayed copy
  assign rise_pulse = sync_p0[SYNC_STAGES-1] & ~dly_p1;

endmodule

// File: rtl/mm_operand_loader.sv
// Collects eight strobed operand bytes into matrices A and B and hands the
// complete set to the multiplier core over a valid/ready handshake.
module mm_operand_loader
  import mm_pkg::*;
#(
  parameter int ELEM_W      = MM_ELEM_W,
  parameter int SYNC_STAGES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              strobe_in,
  input  logic [ELEM_W-1:0] data_in,
  input  logic              clear,
  output logic [4*ELEM_W-1:0] mat_a,
  output logic [4*ELEM_W-1:0] mat_b,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [2:0]        load_idx,
  output logic              busy,
  output logic              overrun
);

  mm_state_e         state;
  logic [ELEM_W-1:0] elem_q [MM_N_ELEM];
  logic              strobe_pulse;
  logic              edge_ok;
  logic              transfer;
  logic              wr_en;
  logic [2:0]        wr_idx;

  mm_sync_edge #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_edge (
    .clk        (clk),
    .rst_n      (rst_n),
    .async_in   (strobe_in),
    .rise_pulse (strobe_pulse)
  );

  assign edge_ok  = strobe_pulse & ena;
  assign transfer = out_valid & out_ready;

  // Element write select: clear drops the edge; a transfer edge starts the next set at A00
  always_comb begin
    wr_en  = 1'b0;
    wr_idx = load_idx;
    if (!clear && edge_ok) begin
      if (state == ST_LOAD) begin
        wr_en = 1'b1;
      end else if (transfer) begin
        wr_en  = 1'b1;
        wr_idx = IDX_A00;
      end
    end
  end

  // Load FSM, index counter, handshake and sticky overrun; clear > transfer > edge
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_LOAD;
      load_idx  <= 3'd0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else if (clear) begin
      state     <= ST_LOAD;
      load_idx  <= 3'd0;
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (edge_ok) begin
            if (load_idx == IDX_B11) begin
              load_idx  <= 3'd0;
              out_valid <= 1'b1;
              state     <= ST_HOLD;
            end else begin
              load_idx <= load_idx + 3'd1;
            end
          end
        end
        ST_HOLD: begin
          if (transfer) begin
            out_valid <= 1'b0;
            state     <= ST_LOAD;
            if (edge_ok) load_idx <= IDX_A01;
          end else if (edge_ok) begin
            overrun <= 1'b1;
          end
        end
        default: begin
          state <= ST_LOAD;
        end
      endcase
    end
  end

  // Element registers: only the addressed element changes, values survive clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < MM_N_ELEM; i++) elem_q[i] <= '0;
    end else if (wr_en) begin
      elem_q[wr_idx] <= data_in;
    end
  end

  assign mat_a = {elem_q[IDX_A11], elem_q[IDX_A10], elem_q[IDX_A01], elem_q[IDX_A00]};
  assign mat_b = {elem_q[IDX_B11], elem_q[IDX_B10], elem_q[IDX_B01], elem_q[IDX_B00]};
  assign busy  = (load_idx != 3'd0) | out_valid;

endmodule

// File: tb/tb_mm_operand_loader.sv
// Directed testbench for mm_operand_loader.
module tb_mm_operand_loader;

  logic        clk;
  logic        rst_n;
  logic        ena;
  logic        strobe_in;
  logic [7:0]  data_in;
  logic        clear;
  logic [31:0] mat_a;
  logic [31:0] mat_b;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  load_idx;
  logic        busy;
  logic        overrun;

  int n_cmp  = 0;
  int n_fail = 0;

  mm_operand_loader #(
    .ELEM_W      (8),
    .SYNC_STAGES (2)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .ena       (ena),
    .strobe_in (strobe_in),
    .data_in   (data_in),
    .clear     (clear),
    .mat_a     (mat_a),
    .mat_b     (mat_b),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .load_idx  (load_idx),
    .busy      (busy),
    .overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One strobe: rise at a negedge, write lands on the 3rd posedge, then low long enough to re-arm
  task automatic strobe(input logic [7:0] d);
    @(negedge clk);
    data_in   = d;
    strobe_in = 1'b1;
    repeat (4) @(negedge clk);
    strobe_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic load_set(input logic [7:0] base);
    for (int i = 0; i < 8; i++) strobe(base + 8'(i));
  endtask

  task automatic do_transfer();
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    @(negedge clk);
    clear = 1'b1;
    @(negedge clk);
    clear = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; ena = 1'b1; strobe_in = 1'b0; data_in = 8'h00;
    clear = 1'b0; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({mat_a, mat_b, out_valid, load_idx, busy, overrun} !== 70'd0) begin
      n_fail++;
      $display("FAIL reset_outputs: got a=%h b=%h v=%b idx=%0d busy=%b ovr=%b, want all 0",
               mat_a, mat_b, out_valid, load_idx, busy, overrun);
    end
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  task automatic test_full_load();
    for (int i = 0; i < 3; i++) strobe(8'(i + 1));
    n_cmp++;
    if (load_idx !== 3'd3 || busy !== 1'b1 || out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL partial_load: got idx=%0d busy=%b v=%b, want idx=3 busy=1 v=0",
               load_idx, busy, out_valid);
    end
    for (int i = 3; i < 8; i++) strobe(8'(i + 1));
    n_cmp++;
    if (out_valid !== 1'b1 || mat_a !== 32'h04030201 || mat_b !== 32'h08070605 ||
        load_idx !== 3'd0 || busy !== 1'b1) begin
      n_fail++;
      $display("FAIL full_load: got v=%b a=%h b=%h idx=%0d busy=%b, want v=1 a=04030201 b=08070605 idx=0 busy=1",
               out_valid, mat_a, mat_b, load_idx, busy);
    end
  endtask

  task automatic test_overrun();
    strobe(8'h99);
    n_cmp++;
    if (overrun !== 1'b1 || mat_a !== 32'h04030201 || mat_b !== 32'h08070605 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL overrun_set: got ovr=%b a=%h b=%h v=%b, want ovr=1 a=04030201 b=08070605 v=1",
               overrun, mat_a, mat_b, out_valid);
    end
    do_transfer();
    n_cmp++;
    if (out_valid !== 1'b0 || overrun !== 1'b1 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL overrun_after_xfer: got v=%b ovr=%b busy=%b, want v=0 ovr=1 busy=0",
               out_valid, overrun, busy);
    end
    // out_ready without valid must do nothing
    do_transfer();
    n_cmp++;
    if (out_valid !== 1'b0 || load_idx !== 3'd0 || mat_a !== 32'h04030201) begin
      n_fail++;
      $display("FAIL ready_no_valid: got v=%b idx=%0d a=%h, want v=0 idx=0 a=04030201",
               out_valid, load_idx, mat_a);
    end
  endtask

  task automatic test_back_to_back();
    pulse_clear();
    n_cmp++;
    if (overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL clear_overrun: got ovr=%b, want 0", overrun);
    end
    load_set(8'h21);
    // Edge pulse lands on the 3rd posedge after the rise; ready is up exactly for that edge
    @(negedge clk);
    data_in   = 8'hAA;
    strobe_in = 1'b1;
    @(negedge clk);
    @(negedge clk);
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    n_cmp++;
    if (out_valid !== 1'b0 || mat_a !== 32'h242322AA || load_idx !== 3'd1 || overrun !== 1'b0) begin
      n_fail++;
      $display("FAIL xfer_with_edge: got v=%b a=%h idx=%0d ovr=%b, want v=0 a=242322aa idx=1 ovr=0",
               out_valid, mat_a, load_idx, overrun);
    end
    strobe_in = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  task automatic test_clear();
    strobe(8'h50);
    strobe(8'h51);
    n_cmp++;
    if (load_idx !== 3'd3) begin
      n_fail++;
      $display("FAIL clear_preload: got idx=%0d, want 3", load_idx);
    end
    pulse_clear();
    n_cmp++;
    if (load_idx !== 3'd0 || busy !== 1'b0 || overrun !== 1'b0 || mat_a !== 32'h245150AA) begin
      n_fail++;
      $display("FAIL clear_abort: got idx=%0d busy=%b ovr=%b a=%h, want idx=0 busy=0 ovr=0 a=245150aa",
               load_idx, busy, overrun, mat_a);
    end
    for (int i = 0; i < 8; i++) strobe(8'h11 * 8'(i + 1));
    n_cmp++;
    if (out_valid !== 1'b1 || mat_a !== 32'h44332211 || mat_b !== 32'h88776655) begin
      n_fail++;
      $display("FAIL clear_reload: got v=%b a=%h b=%h, want v=1 a=44332211 b=88776655",
               out_valid, mat_a, mat_b);
    end
    do_transfer();
  endtask

  task automatic test_ena();
    ena = 1'b0;
    for (int i = 0; i < 4; i++) strobe(8'hE0 + 8'(i));
    n_cmp++;
    if (load_idx !== 3'd0 || overrun !== 1'b0 || mat_a !== 32'h44332211) begin
      n_fail++;
      $display("FAIL ena_low_load: got idx=%0d ovr=%b a=%h, want idx=0 ovr=0 a=44332211",
               load_idx, overrun, mat_a);
    end
    ena = 1'b1;
    load_set(8'hA0);
    n_cmp++;
    if (out_valid !== 1'b1 || mat_a !== 32'hA3A2A1A0 || mat_b !== 32'hA7A6A5A4) begin
      n_fail++;
      $display("FAIL ena_resume: got v=%b a=%h b=%h, want v=1 a=a3a2a1a0 b=a7a6a5a4",
               out_valid, mat_a, mat_b);
    end
    ena = 1'b0;
    strobe(8'hEE);
    n_cmp++;
    if (overrun !== 1'b0 || out_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL ena_low_hold: got ovr=%b v=%b, want ovr=0 v=1", overrun, out_valid);
    end
    do_transfer();
    n_cmp++;
    if (out_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL ena_low_xfer: got v=%b, want 0", out_valid);
    end
    ena = 1'b1;
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) strobe(8'h30 + 8'(i));
    n_cmp++;
    if (load_idx !== 3'd5) begin
      n_fail++;
      $display("FAIL areset_preload: got idx=%0d, want 5", load_idx);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mat_a, mat_b, out_valid, load_idx, busy, overrun} !== 70'd0) begin
      n_fail++;
      $display("FAIL areset_midload: got a=%h b=%h v=%b idx=%0d busy=%b ovr=%b, want all 0",
               mat_a, mat_b, out_valid, load_idx, busy, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    load_set(8'h61);
    strobe(8'h77);
    n_cmp++;
    if (out_valid !== 1'b1 || overrun !== 1'b1 || mat_b !== 32'h68676665) begin
      n_fail++;
      $display("FAIL areset_prehold: got v=%b ovr=%b b=%h, want v=1 ovr=1 b=68676665",
               out_valid, overrun, mat_b);
    end
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({mat_a, mat_b, out_valid, load_idx, busy, overrun} !== 70'd0) begin
      n_fail++;
      $display("FAIL areset_hold: got a=%h b=%h v=%b idx=%0d busy=%b ovr=%b, want all 0",
               mat_a, mat_b, out_valid, load_idx, busy, overrun);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_full_load();
    test_overrun();
    test_back_to_back();
    test_clear();
    test_ena();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
